// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: a table of 2-bit saturating counters and branch targets, with mispredict redirect.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [IDX_W-1:0] pred_idx, upd_idx;
    logic [TAG_W-1:0] pred_tag, upd_tag;
    logic             pred_hit, upd_hit, upd_mispredict;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign pred_tag = pred_pc[31:IDX_W+2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

    assign pred_hit = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_mispredict = (upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_target != upd_pred_target));

    // Prediction reads the _q arrays, so a same-edge update on the same index is not visible yet.
    always_comb begin
        pred_valid_d     = pred_req;
        pred_taken_d     = pred_hit && ctr_q[pred_idx][1];
        pred_target_d    = pred_taken_d ? target_q[pred_idx] : pred_pc + 32'd4;
        redirect_valid_d = upd_valid && upd_mispredict;
        redirect_pc_d    = upd_taken ? upd_target : upd_pc + 32'd4;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                    if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q          <= '0;
            tag_q            <= '{default: '0};
            target_q         <= '{default: '0};
            ctr_q            <= '{default: 2'b01};
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_target_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            target_q         <= target_d;
            ctr_q            <= ctr_d;
            pred_valid_q     <= pred_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // A redirect cycle squashes the wrong-path prediction.
    assign pred_valid     = pred_valid_q && !redirect_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_target    = pred_target_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_valid) begin
            stat_br_d = stat_br_q + 32'd1;
            if (upd_mispredict) stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped predictor entries; power of two, 2..256.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pred_req  in  1  fetch requests a prediction for pred_pc.
- pred_pc  in  32  fetch PC.
- pred_valid  out  1  prediction result valid.
- pred_taken  out  1  predicted direction.
- pred_target  out  32  predicted next PC.
- upd_valid  in  1  one resolved conditional branch from execute (comparator result).
- upd_pc  in  32  resolved branch PC.
- upd_taken  in  1  actual direction (comparator out).
- upd_target  in  32  actual taken target.
- upd_pred_taken  in  1  direction predicted earlier for this branch.
- upd_pred_target  in  32  next PC predicted earlier for this branch.
- redirect_valid  out  1  one-cycle mispredict flush pulse.
- redirect_pc  out  32  correct next PC.
- stat_branches  out  32  resolved-branch count.
- stat_mispredicts  out  32  mispredict count.

Function
REQ-003 Index SHALL be pc[log2(ENTRIES)+1:2]; tag SHALL be pc[31:log2(ENTRIES)+2]; pc[1:0] ignored.
REQ-004 Each entry SHALL hold: valid bit, tag, 32-bit target, 2-bit saturating counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-005 Hit SHALL mean the indexed entry is valid and its tag matches.
REQ-006 Prediction latency SHALL be 1 cycle: pred_req high at edge N gives pred_valid=1 during cycle N+1; pred_valid=0 when pred_req was low.
REQ-007 pred_taken SHALL be hit AND counter[1].
REQ-008 pred_target SHALL be the entry target when pred_taken=1, else pred_pc+4, wrapping modulo 2^32.
REQ-009 Update with hit SHALL increment the counter on taken and decrement on not-taken, saturating at 11 and 00. A taken update SHALL also overwrite the target.
REQ-010 Update with miss and upd_taken=1 SHALL allocate the entry (replacing any occupant): valid=1, new tag, target=upd_target, counter=10.
REQ-011 Update with miss and upd_taken=0 SHALL leave the array unchanged.
REQ-012 Mispredict SHALL be (upd_taken != upd_pred_taken) OR (upd_taken AND upd_target != upd_pred_target).
REQ-013 On a mispredict update at edge N, redirect_valid SHALL be 1 for exactly cycle N+1, with redirect_pc = upd_target if taken, else upd_pc+4.
REQ-014 In any cycle where redirect_valid=1, pred_valid SHALL be forced to 0, squashing the wrong-path prediction.
REQ-015 Prediction and update at the same edge on the same index SHALL read pre-update state; the update SHALL still be applied.
REQ-016 Back-to-back updates SHALL be accepted every cycle with no stall; there is no ready signal.

Reset
REQ-017 rst_n low SHALL immediately clear all valid bits and set all counters to 01.
REQ-018 rst_n low SHALL immediately drive pred_valid, pred_taken, redirect_valid, stat_branches and stat_mispredicts to 0, and pred_target and redirect_pc to 0x00000000.
REQ-019 Reset asserted mid-operation SHALL discard any pending prediction or redirect; the first output after deassertion SHALL reflect only post-reset requests.

Configuration
REQ-020 Macro BRANCH_PREDICTOR_STATS_EN defined: stat_branches SHALL increment on every upd_valid, and stat_mispredicts on every mispredict; both wrap from 0xFFFFFFFF to 0.
REQ-021 Macro BRANCH_PREDICTOR_STATS_EN undefined: no counter logic; both stat outputs SHALL be constant 0. Ports SHALL be present in both builds.

Verification
REQ-022 After reset, pred_req with pred_pc=0x00000100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x00000104.
REQ-023 Update pc=0x100, taken, target=0x80, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x80. A later predict of 0x100 -> taken, target 0x80.
REQ-024 Counter saturation: 3 taken updates to 0x100 then 1 not-taken -> still predicts taken. A 2nd not-taken -> predicts not-taken, target 0x104.
REQ-025 Aliasing, ENTRIES=16: allocate 0x100, then taken update of 0x140 (same index, different tag) -> predict 0x100 misses (target 0x104); 0x140 hits.
REQ-026 Same-edge predict and update on 0x100 -> prediction shows old state; redirect cycle forces pred_valid=0. With STATS_EN, 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2; without STATS_EN both stay 0.
